bridge_1xn: RTL and testbench

- Generalised successor of the CPU data-side 1-to-2 bridge.
- Routes one SRAM-style CPU data port to N slave SRAM-style ports by parametrised address windows, e.g. data RAM, confreg, future peripherals.
- Tracks each read for RD_LAT cycles and returns the selected slave's data.
- Flags accesses that decode to no slave and counts them.

---
 rtl/bridge_1xn.sv | 140 ++++++++++++++
 tb/tb_bridge_1xn.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_1xn.sv
// bridge_1xn: routes one SRAM-style CPU data port to N slave ports by address
// window. Each access is tracked for RD_LAT cycles so that the selected slave's
// read data returns on the CPU port. Accesses that match no window are flagged
// and counted.
module bridge_1xn #(
    parameter int unsigned     N         = 2,
    parameter int unsigned     RD_LAT    = 1,
    parameter logic [32*N-1:0] BASE      = {32'h0000_0000, 32'hbfaf_0000},
    parameter logic [32*N-1:0] MASK      = {32'h0000_0000, 32'hffff_0000},
    parameter logic [31:0]     DEF_RDATA = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_data_en,
    input  logic [3:0]        cpu_data_wen,
    input  logic [31:0]       cpu_data_addr,
    input  logic [31:0]       cpu_data_wdata,
    output logic [31:0]       cpu_data_rdata,
    output logic              cpu_rvalid,
    output logic              dec_err,
    output logic [15:0]       miss_cnt,
    output logic [N-1:0]      slv_en,
    output logic [4*N-1:0]    slv_wen,
    output logic [32*N-1:0]   slv_addr,
    output logic [32*N-1:0]   slv_wdata,
    input  logic [32*N-1:0]   slv_rdata
);

    localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LAST = RD_LAT - 1;

    logic [N-1:0]  hit_c;
    logic [IW-1:0] sel_c;
    logic          miss_c;

    logic [RD_LAT-1:0] v_q;
    logic [RD_LAT-1:0] rd_q;
    logic [RD_LAT-1:0] miss_q;
    logic [IW-1:0]     idx_q [RD_LAT];

    logic [31:0] slv_mux_c;
    logic [15:0] miss_cnt_q;
    logic [15:0] miss_cnt_d;

    // Window match per slave, lowest index wins on overlap
    always_comb begin
        hit_c  = '0;
        sel_c  = '0;
        miss_c = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            hit_c[i] = ((cpu_data_addr & MASK[32*i +: 32]) ==
                        (BASE[32*i +: 32] & MASK[32*i +: 32]));
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (hit_c[i] && miss_c) begin
                sel_c  = IW'(i);
                miss_c = 1'b0;
            end
        end
    end

    // Request fan-out: only the selected slave sees the access, others read zero
    always_comb begin
        slv_en    = '0;
        slv_wen   = '0;
        slv_addr  = '0;
        slv_wdata = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cpu_data_en && !miss_c && (sel_c == IW'(i))) begin
                slv_en[i]              = 1'b1;
                slv_wen[4*i +: 4]      = cpu_data_wen;
                slv_addr[32*i +: 32]   = cpu_data_addr;
                slv_wdata[32*i +: 32]  = cpu_data_wdata;
            end
        end
    end

    // Tracking pipeline: one entry per cycle, never stalls
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_q    <= '0;
            rd_q   <= '0;
            miss_q <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                idx_q[s] <= '0;
            end
        end else begin
            v_q[0]    <= cpu_data_en;
            rd_q[0]   <= (cpu_data_wen == 4'h0);
            miss_q[0] <= miss_c;
            idx_q[0]  <= sel_c;
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                v_q[s]    <= v_q[s-1];
                rd_q[s]   <= rd_q[s-1];
                miss_q[s] <= miss_q[s-1];
                idx_q[s]  <= idx_q[s-1];
            end
        end
    end

    // Select returning slave's data by the tracked index
    always_comb begin
        slv_mux_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q[LAST] == IW'(i)) begin
                slv_mux_c = slv_rdata[32*i +: 32];
            end
        end
    end

    // Return side, driven from the last tracking stage
    always_comb begin
        cpu_rvalid     = v_q[LAST] & rd_q[LAST];
        dec_err        = v_q[LAST] & miss_q[LAST];
        cpu_data_rdata = '0;
        if (cpu_rvalid) begin
            cpu_data_rdata = miss_q[LAST] ? DEF_RDATA : slv_mux_c;
        end
    end

    // Saturating decode-miss counter next state
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (dec_err && (miss_cnt_q != 16'hffff)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    // Decode-miss counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_bridge_1xn.sv
// Testbench for bridge_1xn: two instances (3-slave RD_LAT=2 map, default 1x2 map)
// driven by directed and random accesses; a monitor compares against a queue of
// expected returns built from the address-window rules.
module tb_bridge_1xn;

    localparam int unsigned LA    = 2;
    localparam int unsigned LB    = 1;
    localparam logic [31:0] DEF_A = 32'hdead_0bad;

    localparam logic [31:0] WB_A [3] = '{32'h1fc0_0000, 32'h1faf_0000, 32'h0000_0000};
    localparam logic [31:0] WM_A [3] = '{32'hfff0_0000, 32'hffff_0000, 32'hf000_0000};
    localparam logic [31:0] WB_B [2] = '{32'hbfaf_0000, 32'h0000_0000};
    localparam logic [31:0] WM_B [2] = '{32'hffff_0000, 32'h0000_0000};

    typedef struct {
        int unsigned due;
        logic        rv;
        logic [31:0] rd;
        logic        de;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_a, rstn_b;

    logic        en_a, rvalid_a, decerr_a;
    logic [3:0]  wen_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [15:0] mcnt_a;
    logic [2:0]  sen_a;
    logic [11:0] swen_a;
    logic [95:0] saddr_a, swdata_a, srdata_a;

    logic        en_b, rvalid_b, decerr_b;
    logic [3:0]  wen_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [15:0] mcnt_b;
    logic [1:0]  sen_b;
    logic [7:0]  swen_b;
    logic [63:0] saddr_b, swdata_b, srdata_b;

    bridge_1xn #(
        .N         (3),
        .RD_LAT    (LA),
        .BASE      ({32'h0000_0000, 32'h1faf_0000, 32'h1fc0_0000}),
        .MASK      ({32'hf000_0000, 32'hffff_0000, 32'hfff0_0000}),
        .DEF_RDATA (DEF_A)
    ) u_a (
        .clk(clk), .resetn(rstn_a), .cpu_data_en(en_a), .cpu_data_wen(wen_a),
        .cpu_data_addr(addr_a), .cpu_data_wdata(wdata_a), .cpu_data_rdata(rdata_a),
        .cpu_rvalid(rvalid_a), .dec_err(decerr_a), .miss_cnt(mcnt_a),
        .slv_en(sen_a), .slv_wen(swen_a), .slv_addr(saddr_a),
        .slv_wdata(swdata_a), .slv_rdata(srdata_a)
    );

    bridge_1xn u_b (
        .clk(clk), .resetn(rstn_b), .cpu_data_en(en_b), .cpu_data_wen(wen_b),
        .cpu_data_addr(addr_b), .cpu_data_wdata(wdata_b), .cpu_data_rdata(rdata_b),
        .cpu_rvalid(rvalid_b), .dec_err(decerr_b), .miss_cnt(mcnt_b),
        .slv_en(sen_b), .slv_wen(swen_b), .slv_addr(saddr_b),
        .slv_wdata(swdata_b), .slv_rdata(srdata_b)
    );

    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned cyc  = 0;
    int unsigned ecnt [2] = '{0, 0};
    exp_t qa[$];
    exp_t qb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Slave read data is a fixed function of slave index and address
    function automatic logic [31:0] sdat(input int i, input logic [31:0] a);
        return a ^ (32'h5a5a_0000 + 32'(i) * 32'h0011_1111);
    endfunction

    // Reference decode: lowest matching window, -1 for none
    function automatic int ref_sel(input bit is_b, input logic [31:0] a);
        if (!is_b) begin
            for (int i = 0; i < 3; i++)
                if ((a & WM_A[i]) == (WB_A[i] & WM_A[i])) return i;
        end else begin
            for (int i = 0; i < 2; i++)
                if ((a & WM_B[i]) == (WB_B[i] & WM_B[i])) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Slave models: return sdat() exactly RD_LAT cycles after a read enable
    logic [2:0]  a_v1 = '0, a_v2 = '0;
    logic [31:0] a_ad1 [3];
    logic [31:0] a_ad2 [3];
    logic [1:0]  b_v1 = '0;
    logic [31:0] b_ad1 [2];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            a_v1[i]  <= sen_a[i] && (swen_a[4*i +: 4] == 4'h0);
            a_ad1[i] <= saddr_a[32*i +: 32];
            a_v2[i]  <= a_v1[i];
            a_ad2[i] <= a_ad1[i];
        end
        for (int i = 0; i < 2; i++) begin
            b_v1[i]  <= sen_b[i] && (swen_b[4*i +: 4] == 4'h0);
            b_ad1[i] <= saddr_b[32*i +: 32];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            srdata_a[32*i +: 32] = a_v2[i] ? sdat(i, a_ad2[i]) : (32'hbad0_0000 | 32'(i));
        for (int i = 0; i < 2; i++)
            srdata_b[32*i +: 32] = b_v1[i] ? sdat(i, b_ad1[i]) : (32'hbad1_0000 | 32'(i));
    end

    // Build the expected return of one access from the window rules
    task automatic push_exp(input bit is_b, input logic en, input logic [3:0] wen,
                            input logic [31:0] addr);
        exp_t e;
        int   s;
        s = ref_sel(is_b, addr);
        if (en && ((wen == 4'h0) || (s < 0))) begin
            e.due = cyc + (is_b ? LB : LA);
            e.rv  = (wen == 4'h0);
            e.de  = (s < 0);
            if (!e.rv)      e.rd = 32'h0;
            else if (s < 0) e.rd = is_b ? 32'h0 : DEF_A;
            else            e.rd = sdat(s, addr);
            if (is_b) qb.push_back(e);
            else      qa.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input logic ae, input logic [3:0] aw, input logic [31:0] aa,
                        input logic be, input logic [3:0] bw, input logic [31:0] ba);
        tick();
        en_a = ae; wen_a = aw; addr_a = aa; wdata_a = $urandom;
        en_b = be; wen_b = bw; addr_b = ba; wdata_b = $urandom;
        push_exp(1'b0, ae, aw, aa);
        push_exp(1'b1, be, bw, ba);
    endtask

    // Monitor one instance: fan-out against decode, returns against the queue
    task automatic mon(input bit is_b, input logic rstn, input logic en,
                       input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] sen, input logic [11:0] swen,
                       input logic [95:0] saddr, input logic [95:0] swdata,
                       input logic rv, input logic [31:0] rd, input logic de,
                       input logic [15:0] mc);
        string      p;
        int         n, s, k;
        logic [2:0] een;
        exp_t       e;
        bit         have;
        p = is_b ? "B" : "A";
        n = is_b ? 2 : 3;
        k = is_b ? 1 : 0;
        if (!rstn) begin
            ecnt[k] = 0;
            if (is_b) qb.delete();
            else      qa.delete();
        end
        s   = ref_sel(is_b, addr);
        een = '0;
        if (en && s >= 0) een[s] = 1'b1;
        chk({p, " slv_en"}, 32'(sen), 32'(een));
        if (en) begin
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s slv_wen[%0d]", p, i), 32'(swen[4*i +: 4]),
                    (i == s) ? 32'(wen) : 32'h0);
                chk($sformatf("%s slv_addr[%0d]", p, i), saddr[32*i +: 32],
                    (i == s) ? addr : 32'h0);
                chk($sformatf("%s slv_wdata[%0d]", p, i), swdata[32*i +: 32],
                    (i == s) ? wdata : 32'h0);
            end
        end
        have = 1'b0;
        if (is_b) begin
            if (qb.size() > 0 && qb[0].due == cyc) begin e = qb.pop_front(); have = 1'b1; end
        end else begin
            if (qa.size() > 0 && qa[0].due == cyc) begin e = qa.pop_front(); have = 1'b1; end
        end
        if (!have) begin
            e.rv = 1'b0; e.rd = 32'h0; e.de = 1'b0;
        end
        chk({p, " cpu_rvalid"}, 32'(rv), 32'(e.rv));
        chk({p, " cpu_data_rdata"}, rd, e.rd);
        chk({p, " dec_err"}, 32'(de), 32'(e.de));
        chk({p, " miss_cnt"}, 32'(mc), ecnt[k]);
        if (e.de && ecnt[k] < 32'h0000_ffff) ecnt[k]++;
    endtask

    // Monitor samples mid-cycle, away from the active edge
    always @(negedge clk) begin
        mon(1'b0, rstn_a, en_a, wen_a, addr_a, wdata_a, sen_a, swen_a, saddr_a, swdata_a,
            rvalid_a, rdata_a, decerr_a, mcnt_a);
        mon(1'b1, rstn_b, en_b, wen_b, addr_b, wdata_b, {1'b0, sen_b}, {4'h0, swen_b},
            {32'h0, saddr_b}, {32'h0, swdata_b}, rvalid_b, rdata_b, decerr_b, mcnt_b);
    end

    logic [31:0] r, ra, rb;
    logic [3:0]  wa, wb;

    initial begin
        rstn_a = 1'b0; rstn_b = 1'b0;
        en_a = 1'b0; wen_a = '0; addr_a = '0; wdata_a = '0;
        en_b = 1'b0; wen_b = '0; addr_b = '0; wdata_b = '0;
        repeat (3) tick();
        rstn_a = 1'b1; rstn_b = 1'b1;
        step(0, 0, 0, 0, 0, 0);

        // Back-to-back reads across slaves; default map conf then RAM
        step(1, 4'h0, 32'h1fc0_0004, 1, 4'h0, 32'hbfaf_f020);
        step(1, 4'h0, 32'h1faf_0008, 1, 4'h0, 32'h8000_1000);
        step(1, 4'h0, 32'h0000_0010, 0, 4'h0, 32'h0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        // Decode miss: read then write
        step(1, 4'h0, 32'h5000_0000, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0);
        step(1, 4'hf, 32'h5000_0000, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        // Window edges and overlap of the default map
        step(1, 4'h0, 32'h1fcf_fffc, 1, 4'h0, 32'hbfaf_0004);
        step(1, 4'h0, 32'h1fd0_0000, 1, 4'h3, 32'hbfaf_0004);
        step(1, 4'h0, 32'h0fff_fffc, 1, 4'h0, 32'hbfb0_0000);
        step(1, 4'h0, 32'h1fae_fffc, 1, 4'h0, 32'hbfae_fffc);
        step(1, 4'h1, 32'h1faf_ffff, 1, 4'h0, 32'h0000_0000);
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // Randomized traffic biased toward the windows
        for (int t = 0; t < 400; t++) begin
            r = $urandom;
            case ($urandom_range(0, 4))
                0:       ra = 32'h1fc0_0000 | (r & 32'h000f_ffff);
                1:       ra = 32'h1faf_0000 | (r & 32'h0000_ffff);
                2:       ra = r & 32'h0fff_ffff;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 1) == 0) ? (32'hbfaf_0000 | (r & 32'h0000_ffff)) : $urandom;
            wa = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            wb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            step(1'($urandom_range(0, 3) != 0), wa, ra, 1'($urandom_range(0, 3) != 0), wb, rb);
        end
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // Reset one cycle after a read: the read must not return
        step(1, 4'h0, 32'h1fc0_0040, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        rstn_a = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        rstn_a = 1'b1;
        repeat (4) step(0, 0, 0, 0, 0, 0);

        // Saturate the miss counter and go past it
        for (int t = 0; t < 65538; t++) step(1, 4'hf, 32'h5000_0000, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0);
        chk("A miss_cnt saturated", 32'(mcnt_a), 32'h0000_ffff);

        // Every expected return must have been consumed
        chk("A queue drained", qa.size(), 0);
        chk("B queue drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
